// File: rtl/iir_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the
// time-multiplexed SOS IIR cascade engine.
package iir_pkg;

    localparam int DW         = 16;
    localparam int FRAC       = 14;
    localparam int NUM_STAGES = 6;
    localparam int ACC_W      = 36;
    localparam int PW         = 2 * DW;

    localparam logic signed [DW-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DW-1:0] SAT_MIN = 16'sh8000;
    localparam int                   ROUND_K = 1 << (FRAC - 1);

    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WB,
        OUT
    } state_t;

endpackage

// File: rtl/iir_sos_mac.sv
// One Direct Form I section datapath: five products registered in CALC,
// then combinational sum, round-half-up, shift and saturate for WB.
module iir_sos_mac
    import iir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] x1,
    input  logic signed [DW-1:0] x2,
    input  logic signed [DW-1:0] y1,
    input  logic signed [DW-1:0] y2,
    input  logic signed [DW-1:0] b0,
    input  logic signed [DW-1:0] b1,
    input  logic signed [DW-1:0] b2,
    input  logic signed [DW-1:0] a1,
    input  logic signed [DW-1:0] a2,
    output logic signed [DW-1:0] y,
    output logic                 sat
);

    logic signed [PW-1:0]    prod [5];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) prod[i] <= '0;
        end else if (load) begin
            prod[0] <= b0 * x;
            prod[1] <= b1 * x1;
            prod[2] <= b2 * x2;
            prod[3] <= a1 * y1;
            prod[4] <= a2 * y2;
        end
    end

    // Feedback terms are subtracted: a0 is an implied 1.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc     = ACC_W'(prod[0]) + ACC_W'(prod[1]) + ACC_W'(prod[2])
                - ACC_W'(prod[3]) - ACC_W'(prod[4]);
        shifted = (acc + ACC_W'(ROUND_K)) >>> FRAC;
        y       = shifted[DW-1:0];
        sat     = 1'b0;
        if (shifted > ACC_W'(SAT_MAX)) begin
            y   = SAT_MAX;
            sat = 1'b1;
        end else if (shifted < ACC_W'(SAT_MIN)) begin
            y   = SAT_MIN;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/iir_sos_engine.sv
// Cascade controller: walks the sections through one shared MAC, owns the
// Direct Form I delay line and the valid/ready handshakes.
module iir_sos_engine
    import iir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic [2:0]           stage_index,
    input  logic signed [DW-1:0] b0,
    input  logic signed [DW-1:0] b1,
    input  logic signed [DW-1:0] b2,
    input  logic signed [DW-1:0] a1,
    input  logic signed [DW-1:0] a2,
    output logic                 sat_flag
);

    state_t                state, state_nxt;
    logic [2:0]            k;
    logic [2:0]            k_up;
    logic signed [DW-1:0]  x_cur;
    logic signed [DW-1:0]  dz1 [NUM_STAGES+1];
    logic signed [DW-1:0]  dz2 [NUM_STAGES+1];
    logic signed [DW-1:0]  y;
    logic                  mac_sat;

    assign k_up        = k + 3'd1;
    assign stage_index = k;

    iir_sos_mac u_mac (
        .clk  (clk),
        .rst  (rst),
        .load (state == CALC),
        .x    (x_cur),
        .x1   (dz1[k]),
        .x2   (dz2[k]),
        .y1   (dz1[k_up]),
        .y2   (dz2[k_up]),
        .b0   (b0),
        .b1   (b1),
        .b2   (b2),
        .a1   (a1),
        .a2   (a2),
        .y    (y),
        .sat  (mac_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: state_nxt = WB;
            WB:   state_nxt = (k == LAST_STAGE) ? OUT : CALC;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Section k's y-history lives in d[k+1], which only the next section
    // overwrites (as its x-history), so DF-I state is shared between neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            x_cur    <= '0;
            out_data <= '0;
            sat_flag <= 1'b0;
            // NOTE: the delay line is reset explicitly; an aborted sample must
            // not leave stale history that would colour the next response.
            for (int i = 0; i <= NUM_STAGES; i++) begin
                dz1[i] <= '0;
                dz2[i] <= '0;
            end
        end else begin
            sat_flag <= (state == WB) && mac_sat;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_cur <= in_data;
                        k     <= '0;
                    end
                end
                WB: begin
                    dz1[k] <= x_cur;
                    dz2[k] <= dz1[k];
                    if (k == LAST_STAGE) begin
                        dz1[k_up] <= y;
                        dz2[k_up] <= dz1[k_up];
                        out_data  <= y;
                    end else begin
                        x_cur <= y;
                        k     <= k_up;
                    end
                end
                OUT: begin
                    if (out_ready) k <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/iir_sos_engine.md
Name: iir_sos_engine

Overview:
- Time-multiplexed cascade engine for the 6-section second-order-section (SOS) IIR filter.
- Accepts one Q2.14 sample per handshake and walks stage_index 0..NUM_STAGES-1, driving the fixed coefficient ROM. It consumes the ROM's combinational b0/b1/b2/a1/a2 in the same cycle.
- Evaluates each Direct Form I section in turn, feeding each section's output to the next section's input.
- Presents the final filtered sample on a valid/ready output port.

Parameters:
- NUM_STAGES, 6: number of cascaded SOS sections (ROM stage count).
- DW, 16: sample and coefficient width, two's complement.
- FRAC, 14: fractional bits of samples and coefficients (Q2.14).
- ACC_W, 36: accumulator width; holds 5 Q4.28 products without overflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine can accept a sample.
- in_data  in  DW  input sample, Q2.14.
- out_valid  out  1  filtered sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  DW  filtered sample, Q2.14.
- stage_index  out  3  section index to the coefficient ROM.
- b0, b1, b2, a1, a2  in  DW each  coefficients for stage_index, Q2.14, valid in the same cycle.
- sat_flag  out  1  one-cycle pulse when any section output saturates.

Behaviour:
- Reset (synchronous, active-high; identical mid-operation):
  - in_ready=1, out_valid=0, out_data=0, stage_index=0, sat_flag=0.
  - FSM returns to IDLE.
  - All delay registers are cleared; an in-flight sample is discarded.
- Section equation: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2. a0 is implied 1; a1 and a2 are subtracted.
- Arithmetic:
  - Products are DW x DW signed (Q4.28), sign-extended to ACC_W and summed.
  - Add 2^(FRAC-1) (round half up), then arithmetic shift right by FRAC.
  - Saturate to [-32768, 32767]; sat_flag pulses in the cycle saturation occurs.
- Delay storage: NUM_STAGES+1 pairs d[0..NUM_STAGES] = {z1, z2}.
  - Section k reads x-history from d[k] and y-history from d[k+1].
  - At section k writeback: d[k] <= {x_k, d[k].z1}.
  - If k == NUM_STAGES-1, also d[k+1] <= {y_k, d[k+1].z1}.
  - d[k+1] is therefore still the old history when section k reads it.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data as x_0 and go to CALC with k=0.
  - CALC: drive stage_index=k. Register the 5 products and the 4 delay values. Go to WB.
  - WB: sum, round, saturate, update delays. If k < NUM_STAGES-1, set x_{k+1}=y and k=k+1, return to CALC. Otherwise load out_data=y and go to OUT.
  - OUT: out_valid=1. On out_ready, go to IDLE.
- stage_index holds k during both the CALC and WB cycles.
- Latency: the sample is accepted at edge T. CALC/WB take 2 cycles per section, so out_valid is first high in the cycle after edge T+2*NUM_STAGES, i.e. edge T+12 for NUM_STAGES=6.
- Handshake rules:
  - in_ready=1 only in IDLE. There is no same-cycle accept while out_valid=1 (no output/input overlap).
  - out_data is stable while out_valid=1 and out_ready=0.
  - The next in_ready=1 comes the cycle after the output handshake.
- in_valid is ignored while not in IDLE; in_data is not sampled then.

Decomposition:
- Package iir_pkg holds:
  - DW, FRAC, NUM_STAGES, ACC_W.
  - SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000, ROUND_K=1<<(FRAC-1).
  - State enum {IDLE, CALC, WB, OUT}.
- One sub-module, iir_sos_mac: registered 5-product stage plus combinational sum/round/saturate, with a sat output.
- The FSM and the delay array stay in iir_sos_engine.

Test Plan:
- Reset check: assert rst for 2 cycles -> in_ready=1, out_valid=0, out_data=0, stage_index=0.
- Passthrough: ROM stub gives b0=16'sh4000 with the other coefficients 0 for all stages. Drive in_data=16'sh1234 -> out_data=16'sh1234, out_valid first high 12 cycles after accept, stage_index sequence 0,0,1,1,...,5,5.
- Feedback: stage 0 has a1=16'shE000 (-0.5) and b0=1, other stages are passthrough. Impulse 16'sh2000, then zeros -> outputs 16'sh2000, 16'sh1000, 16'sh0800, 16'sh0400.
- Saturation: all stages b0=16'sh7FFF, in_data=16'sh4000 -> out_data=16'sh7FFF and sat_flag pulses at least once. Input 16'shC000 -> out_data=16'sh8000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, in_valid ignored. Release -> handshake, then in_ready=1 next cycle.
- Reset mid-operation: assert rst during stage 3 of a feedback run -> out_valid never rises for that sample, delays cleared. The next impulse reproduces the clean response 16'sh2000, 16'sh1000, ...
